exp2_sum_accumulator: RTL and testbench
=======================================

EXP2_SUM_ACCUMULATOR -- requirements
Module: exp2_sum_accumulator

Interface
REQ-001 SHALL have parameter BITS, default 16: width of every floating-point value.
REQ-002 SHALL have parameter PRECISION, default "HALF": number format, passed unchanged to the internal add instance.
REQ-003 SHALL have parameter VEC_LEN, default 8: number of exp2 results summed per vector, range 2..1024.
REQ-004 SHALL have parameter ADD_LATENCY, default 3: pipeline latency L of the add instance for this PRECISION, range 1..8.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: a carries an exp2 result.
REQ-008 SHALL have port a, input, BITS: exp2 result from the upstream fm_exp2 stage.
REQ-009 SHALL have port in_ready, output, 1 bit: high when an element can be accepted.
REQ-010 SHALL have port out_valid, output, 1 bit: single-cycle strobe, sum is valid.
REQ-011 SHALL have port sum, output, BITS: floating-point sum of the VEC_LEN accepted elements.
REQ-012 SHALL have port out_overflow, output, 1 bit: sum is +/-infinity or NaN.

Function
REQ-013 SHALL accept an element only in a cycle where in_valid and in_ready are both high; a is ignored in all other cycles.
REQ-014 SHALL have four states: IDLE, ACCUM, REDUCE and DONE.
REQ-015 SHALL hold in_ready high in IDLE and ACCUM and low in REDUCE and DONE.
REQ-016 SHALL, on acceptance in IDLE, clear partial slots P[0..L-1] to +0 and move to ACCUM.
REQ-017 SHALL add accepted element k (0-based within the vector) into slot P[k mod L].
- The add result is written back to that slot exactly L cycles after acceptance.
- Inputs one per cycle or with gaps must give the same sum; a slot is never reissued before its result returns.
REQ-018 SHALL, when element VEC_LEN-1 is accepted, clear the element counter and move to REDUCE.
REQ-019 SHALL in REDUCE, after a drain of L cycles, fold the slots serially in order: P0+P1, then +P2, ... up to +P[L-1].
- Each add is issued L+1 cycles after the previous one.
- For L=1, REDUCE is drain only.
REQ-020 SHALL move to DONE when the final fold completes, assert out_valid with sum for exactly one cycle, then return to IDLE.
REQ-021 SHALL assert out_valid exactly L*(L+1) cycles after the cycle the last element is accepted (12 cycles for L=3).
REQ-022 SHALL keep sum and out_overflow stable from one out_valid until the next.
REQ-023 SHALL use only the shared add module for arithmetic; no rounding other than the adder's.

Reset
REQ-024 SHALL, while rst is high at a clock edge, set the following:
- state IDLE;
- counter 0;
- slots, sum and out_overflow to 0;
- out_valid 0;
- in_ready 1 from the first cycle after rst falls.
REQ-025 SHALL, when rst occurs mid-vector or mid-REDUCE, discard the partial sum, produce no out_valid for that vector, and ignore add results still in the pipeline.

Configuration
REQ-026 SHALL compile overflow detection only when macro EXP2_SUM_OVERFLOW_EN is defined.
- With the macro: out_overflow is set in DONE when sum's exponent field is all ones.
- Without the macro: out_overflow is tied to 0 and no detection logic is built.

Verification (BITS=16, HALF, VEC_LEN=8, L=3)
REQ-027 Back-to-back input: 8 x 16'h3C00 (1.0), in_valid held high -> one out_valid with sum=16'h4800 (8.0), 12 cycles after the last element.
REQ-028 Gapped input: 8 x 1.0 with in_valid toggling every cycle -> sum=16'h4800; no out_valid before the 8th acceptance.
REQ-029 Backpressure: in_valid held high for 16 elements of 16'h4000 (2.0) -> in_ready low from the cycle after the 8th acceptance until out_valid; two sums of 16'h4C00 (16.0); elements presented while in_ready is low are not lost.
REQ-030 Reset mid-vector: 5 x 1.0, rst pulsed, then 8 x 1.0 -> exactly one out_valid with sum=16'h4800.
REQ-031 Overflow with EXP2_SUM_OVERFLOW_EN: 8 x 16'h7800 (32768) -> sum=16'h7C00 and out_overflow=1; without the macro, out_overflow=0.

Source files
------------

// File: rtl/exp2_sum_accumulator.sv
// exp2_sum_accumulator: sums VEC_LEN floating-point exp2 results into one value.
// Accepted elements are interleaved across ADD_LATENCY partial slots, so the
// pipelined adder can take one element per cycle. At the end of a vector the
// slots are folded serially into a single sum.
// Optional feature: define EXP2_SUM_OVERFLOW_EN to build out_overflow detection.

// Pipelined floating-point adder, round-to-nearest-even.
// A tag rides alongside each operation so the caller knows where the result goes.
module exp2_sum_fp_add #(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF",
  parameter int    LATENCY   = 3,
  parameter int    TAG_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [BITS-1:0]  op_a,
  input  logic [BITS-1:0]  op_b,
  output logic             out_vld,
  output logic [TAG_W-1:0] out_tag,
  output logic [BITS-1:0]  res
);
  localparam int EW = (PRECISION == "BFLOAT" || BITS == 32) ? 8 : (BITS == 64) ? 11 : 5;
  localparam int MW = BITS - 1 - EW;
  localparam int W  = MW + 4;  // hidden + fraction + guard/round/sticky
  localparam logic [EW-1:0] EMAX = '1;

  logic            sx, sy, sr;
  logic [EW-1:0]   ex_f, ey_f, ex, ey, d, dc, e;
  logic [MW-1:0]   fx, fy;
  logic [W-1:0]    mx, my, my_s, mn;
  logic [2*W-1:0]  sh;
  logic [W:0]      s;
  logic [BITS-2:0] mag;
  logic [BITS-1:0] res_d;
  int              lz, shl;

  // Combinational add; x always holds the larger magnitude so only y is aligned.
  always_comb begin
    shl = 0;
    if (op_a[BITS-2:0] >= op_b[BITS-2:0]) begin
      sx = op_a[BITS-1]; {ex_f, fx} = op_a[BITS-2:0];
      sy = op_b[BITS-1]; {ey_f, fy} = op_b[BITS-2:0];
    end else begin
      sx = op_b[BITS-1]; {ex_f, fx} = op_b[BITS-2:0];
      sy = op_a[BITS-1]; {ey_f, fy} = op_a[BITS-2:0];
    end
    ex   = (ex_f == '0) ? EW'(1) : ex_f;
    ey   = (ey_f == '0) ? EW'(1) : ey_f;
    mx   = {ex_f != '0, fx, 3'b000};
    my   = {ey_f != '0, fy, 3'b000};
    d    = ex - ey;
    dc   = (d > EW'(W)) ? EW'(W) : d;
    sh   = {my, {W{1'b0}}} >> dc;
    my_s = {sh[2*W-1:W+1], sh[W] | (|sh[W-1:0])};
    s    = (sx == sy) ? ({1'b0, mx} + {1'b0, my_s}) : ({1'b0, mx} - {1'b0, my_s});
    lz   = W;
    for (int i = 0; i < W; i++) if (s[i]) lz = W - 1 - i;
    if (s[W]) begin
      mn = {s[W:2], s[1] | s[0]};
      e  = ex + EW'(1);
    end else begin
      // never normalise below the minimum exponent: that leaves a subnormal
      shl = (lz < int'(ex) - 1) ? lz : int'(ex) - 1;
      mn  = s[W-1:0] << shl;
      e   = ex - EW'(shl);
    end
    if (!mn[W-1]) e = '0;
    // exponent/fraction carry handles mantissa overflow and subnormal->normal
    mag   = {e, mn[W-2:3]} + (BITS-1)'(mn[2] & (mn[1] | mn[0] | mn[3]));
    sr    = (s == '0) ? (sx & sy) : sx;
    res_d = {sr, mag};
    if (e == EMAX) res_d = {sr, EMAX, MW'(0)};
    if (ex_f == EMAX) begin
      if (fx != '0 || (ey_f == EMAX && sx != sy)) res_d = {1'b0, EMAX, 1'b1, (MW-1)'(0)};
      else                                         res_d = {sx, EMAX, MW'(0)};
    end
  end

  logic [LATENCY-1:0] vld_pipe_q;
  logic [TAG_W-1:0]   tag_pipe_q [LATENCY];
  logic [BITS-1:0]    res_pipe_q [LATENCY];

  // Latency-matching shift register; reset flushes in-flight results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_pipe_q[i] <= '0;
        res_pipe_q[i] <= '0;
      end
    end else begin
      vld_pipe_q[0] <= in_vld;
      tag_pipe_q[0] <= in_tag;
      res_pipe_q[0] <= res_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
        res_pipe_q[i] <= res_pipe_q[i-1];
      end
    end
  end

  assign out_vld = vld_pipe_q[LATENCY-1];
  assign out_tag = tag_pipe_q[LATENCY-1];
  assign res     = res_pipe_q[LATENCY-1];
endmodule

module exp2_sum_accumulator #(
  parameter int    BITS        = 16,
  parameter string PRECISION   = "HALF",
  parameter int    VEC_LEN     = 8,
  parameter int    ADD_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] sum,
  output logic            out_overflow
);
  localparam int L  = ADD_LATENCY;
  localparam int TW = (L > 1) ? $clog2(L) : 1;
  localparam int CW = $clog2(VEC_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   slot_q, slot_d;
  logic [3:0]      ph_q, ph_d;   // cycle within a fold period (0..L)
  logic [3:0]      fj_q, fj_d;   // index of the next slot to fold in
  logic [BITS-1:0] p_q [L];
  logic [BITS-1:0] p_d [L];
  logic [BITS-1:0] sum_q, sum_d;

  logic            add_vld, wb_vld;
  logic [TW-1:0]   add_tag, wb_tag;
  logic [BITS-1:0] add_a, add_b, wb_res;
  logic            accept, fold_done;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  // last fold result (or, for L=1, the last element's result) is on the adder output now
  assign fold_done = (state_q == REDUCE) && (fj_q == 4'(L)) && (ph_q == 4'(L - 1));

  exp2_sum_fp_add #(
    .BITS(BITS), .PRECISION(PRECISION), .LATENCY(L), .TAG_W(TW)
  ) u_add (
    .clk(clk), .rst(rst),
    .in_vld(add_vld), .in_tag(add_tag), .op_a(add_a), .op_b(add_b),
    .out_vld(wb_vld), .out_tag(wb_tag), .res(wb_res)
  );

  // Next-state, slot write-back and adder issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    ph_d    = ph_q;
    fj_d    = fj_q;
    p_d     = p_q;
    sum_d   = sum_q;
    add_vld = 1'b0;
    add_tag = slot_q;
    add_a   = a;
    // a slot result returning this cycle is forwarded to a new issue to the same slot
    add_b   = (wb_vld && wb_tag == slot_q) ? wb_res : p_q[slot_q];
    if (wb_vld) p_d[wb_tag] = wb_res;

    case (state_q)
      IDLE: if (accept) begin
        for (int i = 0; i < L; i++) p_d[i] = '0;
        add_vld = 1'b1;
        add_tag = '0;
        add_b   = '0;
        cnt_d   = CW'(1);
        slot_d  = (L == 1) ? '0 : TW'(1);
        state_d = ACCUM;
      end
      ACCUM: if (accept) begin
        add_vld = 1'b1;
        if (cnt_q == CW'(VEC_LEN - 1)) begin
          cnt_d   = '0;
          slot_d  = '0;
          ph_d    = '0;
          fj_d    = 4'd1;
          state_d = REDUCE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          slot_d = (slot_q == TW'(L - 1)) ? '0 : slot_q + TW'(1);
        end
      end
      REDUCE: begin
        if (fold_done) begin
          sum_d   = wb_res;
          state_d = DONE;
        end else if (ph_q == 4'(L)) begin
          // P0 <- P0 + P[j]; P0 holds the previous fold result by now
          add_vld = 1'b1;
          add_tag = '0;
          add_a   = p_q[0];
          add_b   = p_q[fj_q[TW-1:0]];
          ph_d    = '0;
          fj_d    = fj_q + 4'd1;
        end else begin
          ph_d = ph_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      ph_q    <= '0;
      fj_q    <= '0;
      sum_q   <= '0;
      for (int i = 0; i < L; i++) p_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      ph_q    <= ph_d;
      fj_q    <= fj_d;
      sum_q   <= sum_d;
      p_q     <= p_d;
    end
  end

`ifdef EXP2_SUM_OVERFLOW_EN
  localparam int EW = (PRECISION == "BFLOAT" || BITS == 32) ? 8 : (BITS == 64) ? 11 : 5;
  logic ovf_q, ovf_d;

  // Flag an all-ones exponent on the value captured into sum.
  always_comb begin
    ovf_d = ovf_q;
    if (fold_done) ovf_d = &wb_res[BITS-2:BITS-1-EW];
  end

  // Overflow flag register, held alongside sum.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_overflow = ovf_q;
`else
  assign out_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_exp2_sum_accumulator.sv
// Bench for exp2_sum_accumulator (HALF, VEC_LEN=8, L=3): table vectors,
// reset corner sequences and random vectors against a real-arithmetic model.
module tb_exp2_sum_accumulator;
  localparam int VL  = 8;
  localparam int LAT = 3;
`ifdef EXP2_SUM_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_overflow;
  logic [15:0] a, sum;

  int checks = 0;
  int errors = 0;

  exp2_sum_accumulator #(.BITS(16), .PRECISION("HALF"), .VEC_LEN(VL), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .in_ready(in_ready),
    .out_valid(out_valid), .sum(sum), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] sum; logic ovf; } out_t;
  typedef struct { logic [15:0] val; int gap; int count; logic [15:0] exp_sum; logic exp_ovf; } vec_t;

  out_t        outq[$];
  out_t        o;
  vec_t        tbl[6];
  logic [15:0] x[VL];
  logic [15:0] exp_s;
  int          cyc = 0, n_acc = 0, last_acc = 0;
  bit          busy = 1'b0;
  logic [15:0] last_sum = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: half <-> real, exact real add, RNE back to half ----
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    if (e == 0) return m * pow2(-24);
    return (1024 + m) * pow2(e - 25);
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real q, n, w;
    int  e, f;
    if (v == 0.0) return 16'h0000;
    e = -24;
    while (pow2(e + 1) <= v) e++;
    q = (e < -14) ? pow2(-24) : pow2(e - 10);
    n = v / q;
    f = $rtoi(n);
    if ((n - f > 0.5) || (n - f == 0.5 && (f % 2) == 1)) f++;
    w = f * q;
    if (w >= 65536.0) return 16'h7C00;
    if (w < pow2(-14)) return 16'(f);
    e = -14;
    while (pow2(e + 1) <= w) e++;
    return {1'b0, 5'(e + 15), 10'($rtoi(w / pow2(e - 10)) - 1024)};
  endfunction

  function automatic logic [15:0] hadd(input logic [15:0] p, input logic [15:0] q);
    if (p[14:10] == 5'h1F || q[14:10] == 5'h1F) return 16'h7C00;
    return r2h(h2r(p) + h2r(q));
  endfunction

  // element k accumulates into partial k mod L, then partials fold left to right
  function automatic logic [15:0] model_sum(input logic [15:0] v[VL]);
    logic [15:0] part[LAT];
    logic [15:0] acc;
    for (int i = 0; i < LAT; i++) part[i] = 16'h0000;
    for (int k = 0; k < VL; k++) part[k % LAT] = hadd(part[k % LAT], v[k]);
    acc = part[0];
    for (int i = 1; i < LAT; i++) acc = hadd(acc, part[i]);
    return acc;
  endfunction

  // ---- monitor: handshake, backpressure window, latency, output stability ----
  always @(negedge clk) begin
    if (rst) begin
      n_acc    = 0;
      busy     = 1'b0;
      last_sum = 16'h0;
    end else begin
      if (busy) chk("ready_low", 32'(in_ready), 32'd0);
      if (out_valid) begin
        chk("out_expected", 32'(busy), 32'd1);
        chk("latency", 32'(cyc - last_acc), 32'(LAT * (LAT + 1)));
        outq.push_back('{sum, out_overflow});
        busy     = 1'b0;
        last_sum = sum;
      end else begin
        chk("sum_stable", 32'(sum), 32'(last_sum));
      end
      if (in_valid && in_ready) begin
        n_acc++;
        last_acc = cyc;
        if (n_acc % VL == 0) busy = 1'b1;
      end
    end
    cyc++;
  end

  task automatic send(input logic [15:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1;
    a = v;
    for (int t = 0; t < 100; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: in_ready stayed low, element %h not accepted", v);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (outq.size() < n && t < 100) begin @(posedge clk); #1; t++; end
    if (outq.size() < n) begin
      checks++; errors++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", outq.size(), n);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 16'h0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    tbl[0] = '{16'h3C00, 0, 8,  16'h4800, 1'b0};   // back-to-back 1.0
    tbl[1] = '{16'h3C00, 1, 8,  16'h4800, 1'b0};   // in_valid toggling
    tbl[2] = '{16'h4000, 0, 16, 16'h4C00, 1'b0};   // backpressure, two vectors
    tbl[3] = '{16'h3800, 0, 8,  16'h4400, 1'b0};   // 0.5 x 8 = 4.0
    tbl[4] = '{16'h7800, 0, 8,  16'h7C00, OVF_EN}; // overflow to +inf
    tbl[5] = '{16'h0000, 2, 8,  16'h0000, 1'b0};   // zeros with gaps

    for (int i = 0; i < 6; i++) begin
      outq.delete();
      for (int k = 0; k < tbl[i].count; k++) send(tbl[i].val, tbl[i].gap);
      in_valid = 1'b0;
      wait_out(tbl[i].count / VL);
      while (outq.size() > 0) begin
        o = outq.pop_front();
        chk($sformatf("vec%0d_sum", i), 32'(o.sum), 32'(tbl[i].exp_sum));
        chk($sformatf("vec%0d_ovf", i), 32'(o.ovf), 32'(tbl[i].exp_ovf));
      end
      repeat (2) @(posedge clk); #1;
    end

    // reset mid-vector: partial vector discarded
    outq.delete();
    for (int k = 0; k < 5; k++) send(16'h3C00, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < VL; k++) send(16'h3C00, 0);
    wait_out(1);
    repeat (20) @(posedge clk); #1;
    chk("rstmid_count", 32'(outq.size()), 32'd1);
    if (outq.size() > 0) begin
      o = outq.pop_front();
      chk("rstmid_sum", 32'(o.sum), 32'h4800);
    end

    // reset during REDUCE: no output for that vector
    outq.delete();
    for (int k = 0; k < VL; k++) send(16'h3C00, 0);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("rstred_count", 32'(outq.size()), 32'd0);
    for (int k = 0; k < VL; k++) send(16'h4000, 0);
    wait_out(1);
    if (outq.size() > 0) begin
      o = outq.pop_front();
      chk("rstred_sum", 32'(o.sum), 32'h4C00);
    end

    // random vectors with random gaps against the model
    for (int v = 0; v < 30; v++) begin
      for (int k = 0; k < VL; k++)
        x[k] = {1'b0, 5'($urandom_range((v % 5 == 4) ? 29 : 20, 3)), 10'($urandom)};
      exp_s = model_sum(x);
      outq.delete();
      for (int k = 0; k < VL; k++) send(x[k], (v % 3 == 0) ? 0 : int'($urandom_range(2, 0)));
      in_valid = 1'b0;
      wait_out(1);
      if (outq.size() > 0) begin
        o = outq.pop_front();
        chk($sformatf("rand%0d_sum", v), 32'(o.sum), 32'(exp_s));
        chk($sformatf("rand%0d_ovf", v), 32'(o.ovf), 32'(OVF_EN && exp_s[14:10] == 5'h1F));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
